// File: rtl/random_bit_generator_if.sv
// random_bit_generator_if: burst request and bit-stream signals between the controller and the PRBS source.
//   Start           - one-cycle burst request (master -> slave)
//   ModulationOrder - bits per symbol minus one (master -> slave)
//   RandomBitValid  - qualifies RandomBit (slave -> master)
//   RandomBit       - pseudo-random output bit (slave -> master)
`timescale 1ns/1ps
interface random_bit_generator_if;
    logic       Start;
    logic [2:0] ModulationOrder;
    logic       RandomBitValid;
    logic       RandomBit;
    modport master (output Start, ModulationOrder, input RandomBitValid, RandomBit);
    modport slave (input Start, ModulationOrder, output RandomBitValid, RandomBit);
endinterface

// File: rtl/random_bit_generator.sv
// random_bit_generator: PRBS-15 burst source feeding the QAM mapper.
//   Clk  - system clock, rising edge
//   SRst - asynchronous active-low reset
//   bus  - slave side: Start/ModulationOrder in, RandomBitValid/RandomBit out
`timescale 1ns/1ps
module random_bit_generator #(
    parameter int          SYMBOL_COUNT = 8,
    parameter logic [14:0] SEED         = 15'h7FFF
) (
    input logic                  Clk,
    input logic                  SRst,
    random_bit_generator_if.slave bus
);
    localparam int CW = $clog2(SYMBOL_COUNT * 8 + 1);
    typedef enum logic {IDLE, RUN} state_t;
    state_t        state_q, state_d;
    logic [14:0]   lfsr_q, lfsr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] total_q, total_d;
    logic          valid_q, valid_d;
    logic          bit_q, bit_d;
    always_comb begin
        state_d = state_q;
        lfsr_d  = lfsr_q;
        cnt_d   = cnt_q;
        total_d = total_q;
        valid_d = 1'b0;
        bit_d   = 1'b0;
        if (state_q == IDLE) begin
            if (bus.Start) begin
                total_d = CW'(SYMBOL_COUNT) * (CW'(bus.ModulationOrder) + CW'(1));
                cnt_d   = '0;
                state_d = RUN;
            end
        end else begin
            // Outputs are registered, so the bit produced here is visible one edge later.
            valid_d = 1'b1;
            bit_d   = lfsr_q[14];
            lfsr_d  = {lfsr_q[13:0], lfsr_q[14] ^ lfsr_q[13]};
            cnt_d   = cnt_q + CW'(1);
            if (cnt_d == total_q) state_d = IDLE;
        end
    end
    always_ff @(posedge Clk or negedge SRst) begin
        if (!SRst) begin
            state_q <= IDLE;
            lfsr_q  <= SEED;
            cnt_q   <= '0;
            total_q <= '0;
            valid_q <= 1'b0;
            bit_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            cnt_q   <= cnt_d;
            total_q <= total_d;
            valid_q <= valid_d;
            bit_q   <= bit_d;
        end
    end
    assign bus.RandomBitValid = valid_q;
    assign bus.RandomBit      = bit_q;
endmodule

// File: tb/tb_random_bit_generator.sv
// tb_random_bit_generator: scoreboard bench for the PRBS-15 burst source.
`timescale 1ns/1ps
module tb_random_bit_generator;
    localparam int          SC   = 8;
    localparam logic [14:0] SEED = 15'h7FFF;
    localparam int          PER  = 32767;
    logic clk = 1'b0;
    logic srst_n = 1'b0;
    random_bit_generator_if bus ();
    random_bit_generator #(.SYMBOL_COUNT(SC), .SEED(SEED)) dut (
        .Clk  (clk),
        .SRst (srst_n),
        .bus  (bus)
    );
    always #5 clk = ~clk;
    int          n_vec = 0;
    int          n_err = 0;
    logic        exp_q[$];
    logic        got_bits[$];
    logic [14:0] m_lfsr = SEED;
    int          zr = 0;
    int          max_zr = 0;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask
    task automatic push_bits(input int l);
        for (int i = 0; i < l; i++) begin
            exp_q.push_back(m_lfsr[14]);
            m_lfsr = {m_lfsr[13:0], m_lfsr[14] ^ m_lfsr[13]};
        end
    endtask
    always @(negedge clk) begin
        if (bus.RandomBitValid) begin
            chk("q_nonempty", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) chk("bit", bus.RandomBit, exp_q.pop_front());
            got_bits.push_back(bus.RandomBit);
            zr = bus.RandomBit ? 0 : zr + 1;
            if (zr > max_zr) max_zr = zr;
        end else begin
            chk("idle_bit", bus.RandomBit, 0);
        end
    end
    task automatic burst(input logic [2:0] mo, input bit poke_start, input bit toggle_mo);
        int l;
        int len;
        l = SC * (int'(mo) + 1);
        push_bits(l);
        bus.ModulationOrder = mo;
        bus.Start = 1'b1;
        @(negedge clk);
        chk("lat0_valid", bus.RandomBitValid, 0);
        bus.Start = 1'b0;
        @(negedge clk);
        chk("lat1_valid", bus.RandomBitValid, 1);
        len = 0;
        while (bus.RandomBitValid && len < 600) begin
            len++;
            bus.Start = poke_start && (len == 1 || len == l - 1);
            if (toggle_mo && len == 3) bus.ModulationOrder = ~mo;
            @(negedge clk);
        end
        bus.Start = 1'b0;
        chk("burst_len", len, l);
        chk("q_drained", exp_q.size(), 0);
        @(negedge clk);
        chk("post_idle", bus.RandomBitValid, 0);
    endtask
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
    initial begin
        bus.Start = 1'b0;
        bus.ModulationOrder = 3'd0;
        repeat (2) @(negedge clk);
        chk("rst_valid", bus.RandomBitValid, 0);
        srst_n = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("no_start_valid", bus.RandomBitValid, 0);
        end
        burst(3'd0, 0, 0);
        for (int i = 0; i < 8; i++) chk("seed_bit", got_bits[i], 1);
        burst(3'd1, 0, 0);
        for (int i = 8; i < 15; i++) chk("cont_bit", got_bits[i], 1);
        chk("bit15", got_bits[15], 0);
        burst(3'd3, 1, 0);
        repeat (4) begin
            @(negedge clk);
            chk("no_extra_burst", bus.RandomBitValid, 0);
        end
        push_bits(8);
        bus.ModulationOrder = 3'd0;
        bus.Start = 1'b1;
        @(negedge clk);
        bus.Start = 1'b0;
        repeat (3) @(negedge clk);
        chk("pre_rst_valid", bus.RandomBitValid, 1);
        #2 srst_n = 1'b0;
        #1 chk("async_valid", bus.RandomBitValid, 0);
        chk("async_bit", bus.RandomBit, 0);
        exp_q.delete();
        got_bits.delete();
        m_lfsr = SEED;
        zr = 0;
        max_zr = 0;
        repeat (2) @(negedge clk);
        srst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_valid", bus.RandomBitValid, 0);
        burst(3'd1, 0, 0);
        for (int i = 0; i < 15; i++) chk("reseed_bit", got_bits[i], 1);
        chk("reseed_bit15", got_bits[15], 0);
        burst(3'd7, 0, 1);
        while (got_bits.size() < PER + 15) burst(3'd7, 0, 0);
        for (int i = 0; i + PER < got_bits.size(); i++) chk("period", got_bits[i + PER], got_bits[i]);
        chk("max_zero_run", max_zr, 14);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
